// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter sharing the transmit async FIFO
// write port among NUM_REQ word sources. Each accepted word is followed by
// a mandatory dead cycle so the FIFO full flag can settle, and a grant is
// forcibly rotated after MAX_BURST words so no source can starve the rest.
module fifo_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 34,
    parameter int MAX_BURST = 8
) (
    input  logic                      pclk,
    input  logic                      preset_n,
    input  logic                      i_arb_enable,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ-1:0]        i_req_last,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic                      i_fifo_write_full,
    output logic [DATA_W-1:0]         o_fifo_write_data,
    output logic                      o_fifo_write_inc,
    output logic [NUM_REQ-1:0]        o_grant_onehot,
    output logic                      o_busy
);

    localparam int          IW   = (NUM_REQ > 2) ? 2 : 1;
    localparam logic [7:0]  MAXB = 8'(MAX_BURST);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_GAP} state_t;

    state_t              r_state, w_state_n;
    logic [IW-1:0]       r_gidx, w_gidx_n;
    logic [IW-1:0]       r_rr_ptr, w_rr_n;
    logic [7:0]          r_burst_cnt, w_cnt_n;
    logic                r_last, w_last_n;
    logic [DATA_W-1:0]   r_wdata, w_wdata_n;
    logic                r_winc, w_winc_n;
    logic [NUM_REQ-1:0]  r_grant, w_grant_n;
    logic                r_busy;

    logic [DATA_W-1:0]   w_req_word [NUM_REQ];
    logic                w_found;
    logic [IW-1:0]       w_pick;
    logic [IW-1:0]       w_cand;
    logic                w_gvalid;
    logic                w_xfer;

    // Split the flat data bus into one word per requester
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_req_word[i] = i_req_data[i*DATA_W +: DATA_W];
        end
    end

    // Round-robin search: first valid requester starting at rr_ptr+1
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_cand = IW'((int'(r_rr_ptr) + i) % NUM_REQ);
            if (!w_found && i_req_valid[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    assign w_gvalid = i_req_valid[r_gidx];
    assign w_xfer   = (r_state == S_XFER) && w_gvalid && !i_fifo_write_full;

    // Only the granted requester can see ready, and only on a real transfer
    always_comb begin
        o_req_ready = '0;
        if (w_xfer) o_req_ready[r_gidx] = 1'b1;
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_n = r_state;
        w_gidx_n  = r_gidx;
        w_rr_n    = r_rr_ptr;
        w_cnt_n   = r_burst_cnt;
        w_last_n  = r_last;
        w_wdata_n = '0;
        w_winc_n  = 1'b0;
        w_grant_n = r_grant;
        case (r_state)
            S_IDLE: begin
                if (i_arb_enable && w_found) begin
                    w_state_n         = S_XFER;
                    w_gidx_n          = w_pick;
                    w_cnt_n           = '0;
                    w_grant_n         = '0;
                    w_grant_n[w_pick] = 1'b1;
                end
            end
            S_XFER: begin
                if (w_xfer) begin
                    w_wdata_n = w_req_word[r_gidx];
                    w_winc_n  = 1'b1;
                    w_last_n  = i_req_last[r_gidx];
                    if (r_burst_cnt < MAXB) w_cnt_n = r_burst_cnt + 8'd1;
                    w_state_n = S_GAP;
                end else if (!w_gvalid) begin
                    // source went away: give the port to someone else
                    w_state_n = S_IDLE;
                    w_rr_n    = r_gidx;
                    w_grant_n = '0;
                end
                // valid but FIFO full: hold the grant and stall
            end
            S_GAP: begin
                if (r_last || (r_burst_cnt == MAXB) || !i_arb_enable) begin
                    w_state_n = S_IDLE;
                    w_rr_n    = r_gidx;
                    w_grant_n = '0;
                end else begin
                    w_state_n = S_XFER;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // State and registered outputs; async reset aborts any burst in flight
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state     <= S_IDLE;
            r_gidx      <= '0;
            r_rr_ptr    <= IW'(NUM_REQ - 1);
            r_burst_cnt <= '0;
            r_last      <= 1'b0;
            r_wdata     <= '0;
            r_winc      <= 1'b0;
            r_grant     <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_gidx      <= w_gidx_n;
            r_rr_ptr    <= w_rr_n;
            r_burst_cnt <= w_cnt_n;
            r_last      <= w_last_n;
            r_wdata     <= w_wdata_n;
            r_winc      <= w_winc_n;
            r_grant     <= w_grant_n;
            r_busy      <= (w_state_n != S_IDLE);
        end
    end

    assign o_fifo_write_data = r_wdata;
    assign o_fifo_write_inc  = r_winc;
    assign o_grant_onehot    = r_grant;
    assign o_busy            = r_busy;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: table-driven single burst, hand-written
// multi-cycle corner cases, and randomized traffic against a reference model.
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 34;
    localparam int MB = 4;

    logic              pclk;
    logic              preset_n;
    logic              en;
    logic [N-1:0]      valid;
    logic [N-1:0]      last;
    logic [N*DW-1:0]   data;
    logic              full;
    logic [N-1:0]      o_req_ready;
    logic [DW-1:0]     o_fifo_write_data;
    logic              o_fifo_write_inc;
    logic [N-1:0]      o_grant_onehot;
    logic              o_busy;

    fifo_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .pclk              (pclk),
        .preset_n          (preset_n),
        .i_arb_enable      (en),
        .i_req_valid       (valid),
        .i_req_last        (last),
        .i_req_data        (data),
        .o_req_ready       (o_req_ready),
        .i_fifo_write_full (full),
        .o_fifo_write_data (o_fifo_write_data),
        .o_fifo_write_inc  (o_fifo_write_inc),
        .o_grant_onehot    (o_grant_onehot),
        .o_busy            (o_busy)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Owner of the port (-1: nobody), whether a word went out at the last
    // edge (so this cycle is the dead cycle), words sent in this grant.
    int              m_owner;
    int              m_rr;
    int              m_cnt;
    bit              m_wrote;
    bit              m_last;
    logic [DW-1:0]   m_word;
    int              m_xfer_idx;

    task automatic model_reset();
        m_owner = -1; m_rr = N - 1; m_cnt = 0;
        m_wrote = 0;  m_last = 0;   m_word = '0; m_xfer_idx = -1;
    endtask

    function automatic logic [DW-1:0] word_of(input int i);
        return data[i*DW +: DW];
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        r = '0;
        if (m_owner >= 0 && !m_wrote && valid[m_owner] && !full) r[m_owner] = 1'b1;
        return r;
    endfunction

    task automatic model_step();
        int c;
        m_xfer_idx = -1;
        if (m_owner < 0) begin
            if (en && valid != '0) begin
                for (int k = 1; k <= N; k++) begin
                    c = (m_rr + k) % N;
                    if (valid[c]) begin
                        m_owner = c;
                        break;
                    end
                end
                m_cnt = 0;
            end
        end else if (!m_wrote) begin
            if (valid[m_owner] && !full) begin
                m_wrote = 1; m_word = word_of(m_owner); m_last = last[m_owner];
                m_cnt = (m_cnt < MB) ? m_cnt + 1 : MB;
                m_xfer_idx = m_owner;
            end else if (!valid[m_owner]) begin
                m_rr = m_owner; m_owner = -1;
            end
        end else begin
            m_wrote = 0; m_word = '0;
            if (m_last || m_cnt == MB || !en) begin
                m_rr = m_owner; m_owner = -1;
            end
        end
    endtask

    task automatic check_regs();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        chk("m_grant", o_grant_onehot, g);
        chk("m_busy",  o_busy, m_owner >= 0);
        chk("m_inc",   o_fifo_write_inc, m_wrote);
        chk("m_data",  o_fifo_write_data, m_word);
    endtask

    task automatic pre();
        #1;
        chk("m_ready", o_req_ready, model_ready());
    endtask

    task automatic clk_edge();
        @(posedge pclk);
        model_step();
        #1;
        check_regs();
    endtask

    task automatic tick();
        pre();
        clk_edge();
    endtask

    task automatic do_reset();
        preset_n = 1'b0;
        #1;
        chk("rst_grant", o_grant_onehot, 0);
        chk("rst_busy",  o_busy, 0);
        chk("rst_inc",   o_fifo_write_inc, 0);
        chk("rst_data",  o_fifo_write_data, 0);
        chk("rst_ready", o_req_ready, 0);
        model_reset();
        @(posedge pclk);
        @(posedge pclk);
        #3 preset_n = 1'b1;
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] w);
        data[i*DW +: DW] = w;
    endtask

    // ---------------- table ----------------
    typedef struct {
        logic [N-1:0]  v;
        logic [N-1:0]  l;
        logic [DW-1:0] d1;
        logic [N-1:0]  e_ready;
        logic [N-1:0]  e_grant;
        logic          e_inc;
        logic          e_busy;
        logic [DW-1:0] e_data;
    } vec_t;

    vec_t tbl [9];

    logic [DW-1:0] cur_w [N];
    logic          cur_l [N];
    int            wcount;
    int            owners [6];
    int            nown;
    logic [N-1:0]  eg;

    initial begin
        preset_n = 1'b1;
        en = 1'b1; valid = '0; last = '0; full = 1'b0;
        for (int i = 0; i < N; i++) set_data(i, 34'h2_DEAD_0000 | 34'(i));
        model_reset();
        #2;
        do_reset();

        // Single burst from requester 1; then all valid to show rr_ptr=1.
        tbl[0] = '{4'b0010, 4'b0000, 34'h1_0000_00A1, 4'b0000, 4'b0010, 1'b0, 1'b1, 34'h0};
        tbl[1] = '{4'b0010, 4'b0000, 34'h1_0000_00A1, 4'b0010, 4'b0010, 1'b1, 1'b1, 34'h1_0000_00A1};
        tbl[2] = '{4'b0010, 4'b0000, 34'h1_0000_00A2, 4'b0000, 4'b0010, 1'b0, 1'b1, 34'h0};
        tbl[3] = '{4'b0010, 4'b0000, 34'h1_0000_00A2, 4'b0010, 4'b0010, 1'b1, 1'b1, 34'h1_0000_00A2};
        tbl[4] = '{4'b0010, 4'b0010, 34'h1_0000_00A3, 4'b0000, 4'b0010, 1'b0, 1'b1, 34'h0};
        tbl[5] = '{4'b0010, 4'b0010, 34'h1_0000_00A3, 4'b0010, 4'b0010, 1'b1, 1'b1, 34'h1_0000_00A3};
        tbl[6] = '{4'b1111, 4'b0000, 34'h1_0000_00A3, 4'b0000, 4'b0000, 1'b0, 1'b0, 34'h0};
        tbl[7] = '{4'b1111, 4'b0000, 34'h1_0000_00A3, 4'b0000, 4'b0100, 1'b0, 1'b1, 34'h0};
        tbl[8] = '{4'b0000, 4'b0000, 34'h1_0000_00A3, 4'b0000, 4'b0000, 1'b0, 1'b0, 34'h0};
        for (int r = 0; r < 9; r++) begin
            valid = tbl[r].v; last = tbl[r].l; set_data(1, tbl[r].d1);
            #1;
            chk($sformatf("tbl%0d_ready", r), o_req_ready, tbl[r].e_ready);
            clk_edge();
            chk($sformatf("tbl%0d_grant", r), o_grant_onehot, tbl[r].e_grant);
            chk($sformatf("tbl%0d_inc", r), o_fifo_write_inc, tbl[r].e_inc);
            chk($sformatf("tbl%0d_busy", r), o_busy, tbl[r].e_busy);
            chk($sformatf("tbl%0d_data", r), o_fifo_write_data, tbl[r].e_data);
        end

        // Round-robin between requesters 0 and 2, 1-word bursts.
        do_reset();
        valid = 4'b0101; last = 4'b0101;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k % 3 == 0)               eg = 4'b0000;
            else if (((k - 1) / 3) % 2 == 0) eg = 4'b0001;
            else                          eg = 4'b0100;
            chk($sformatf("rr_grant_c%0d", k), o_grant_onehot, eg);
        end
        valid = '0; last = '0;
        tick(); tick();

        // Backpressure on requester 3 for 5 cycles.
        do_reset();
        valid = 4'b1000; last = 4'b1000; set_data(3, 34'h3_1234_5678);
        tick();
        full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            pre();
            chk("bp_ready", o_req_ready, 0);
            clk_edge();
            chk("bp_inc", o_fifo_write_inc, 0);
            chk("bp_grant", o_grant_onehot, 4'b1000);
        end
        full = 1'b0;
        pre();
        chk("bp_ready_release", o_req_ready, 4'b1000);
        clk_edge();
        chk("bp_inc_release", o_fifo_write_inc, 1);
        chk("bp_data_release", o_fifo_write_data, 34'h3_1234_5678);
        valid = '0; last = '0;
        tick(); tick();

        // Enable drop in the GAP after the first word.
        do_reset();
        valid = 4'b0001; last = 4'b0000; wcount = 0;
        tick(); if (o_fifo_write_inc) wcount++;
        tick(); if (o_fifo_write_inc) wcount++;
        en = 1'b0;
        tick(); if (o_fifo_write_inc) wcount++;
        chk("en_idle_grant", o_grant_onehot, 0);
        for (int k = 0; k < 5; k++) begin
            tick(); if (o_fifo_write_inc) wcount++;
            chk("en_no_grant", o_busy, 0);
        end
        chk("en_writes", wcount, 1);
        en = 1'b1;
        tick();
        chk("en_regrant", o_grant_onehot, 4'b0001);
        valid = '0;
        tick(); tick();

        // Forced rotation after MB words from requester 0.
        do_reset();
        valid = 4'b0011; last = 4'b0010; nown = 0;
        for (int k = 0; k < 40 && nown < 6; k++) begin
            tick();
            if (o_fifo_write_inc) begin
                owners[nown] = (o_grant_onehot == 4'b0001) ? 0 :
                               (o_grant_onehot == 4'b0010) ? 1 : 9;
                nown++;
            end
        end
        chk("rot_nwrites", nown, 6);
        chk("rot_w0", owners[0], 0);
        chk("rot_w3", owners[3], 0);
        chk("rot_w4", owners[4], 1);
        chk("rot_w5", owners[5], 0);
        valid = '0; last = '0;
        tick(); tick(); tick();

        // Reset asserted during GAP.
        do_reset();
        valid = 4'b0001; last = 4'b0000;
        tick(); tick();
        chk("mid_inc_before_rst", o_fifo_write_inc, 1);
        valid = 4'b1111;
        do_reset();
        tick();
        chk("mid_first_grant", o_grant_onehot, 4'b0001);
        valid = '0;
        tick(); tick(); tick();

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < N; i++) begin
            cur_w[i] = {2'($urandom_range(3)), 32'($urandom)};
            cur_l[i] = ($urandom_range(3) == 0);
        end
        for (int c = 0; c < 600; c++) begin
            en   = ($urandom_range(9) != 0);
            full = ($urandom_range(3) == 0);
            for (int i = 0; i < N; i++) begin
                valid[i] = ($urandom_range(5) != 0);
                last[i]  = cur_l[i];
                set_data(i, cur_w[i]);
            end
            tick();
            if (m_xfer_idx >= 0) begin
                cur_w[m_xfer_idx] = {2'($urandom_range(3)), 32'($urandom)};
                cur_l[m_xfer_idx] = ($urandom_range(3) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter that shares the single 34-bit write port of the transmit async FIFO (`{modifier[1:0], data[31:0]}` entries) among up to four word sources in the pclk domain, for example the APB bridge, a DMA engine and a self-test generator. It grants one requester at a time and forwards that requester's words to the FIFO as one-cycle `fifo_write_inc` pulses. It respects `fifo_write_full` and enforces a maximum burst length so that no requester can starve the others.

## Interface
- `NUM_REQ`, 4: number of requesters (2..4).
- `DATA_W`, 34: FIFO entry width.
- `MAX_BURST`, 8: maximum words per grant before forced rotation (1..255).
- `pclk`  in  1  clock.
- `preset_n`  in  1  reset; asynchronous, active-low.
- `arb_enable`  in  1  when low, no new grants are issued.
- `req_valid`  in  NUM_REQ  per-requester word available.
- `req_last`  in  NUM_REQ  the current word is the last word of the requester's burst.
- `req_data`  in  NUM_REQ*DATA_W  requester i occupies bits `[i*DATA_W +: DATA_W]`.
- `req_ready`  out  NUM_REQ  combinational; the word is accepted this cycle.
- `fifo_write_full`  in  1  FIFO full flag, already synchronized to pclk.
- `fifo_write_data`  out  DATA_W  registered FIFO write data.
- `fifo_write_inc`  out  1  registered one-cycle write strobe.
- `grant_onehot`  out  NUM_REQ  registered current grant; all zeros in IDLE.
- `busy`  out  1  registered; high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, XFER, GAP.
- **IDLE**
  - If `arb_enable` is high and any `req_valid` is high, select the first requester with `req_valid` high, searching from `rr_ptr+1` modulo NUM_REQ.
  - Register `grant_onehot`, clear `burst_cnt`, and go to XFER.
  - Otherwise stay in IDLE.
- **XFER** (granted requester g)
  - A transfer occurs when `req_valid[g]` is high and `fifo_write_full` is low.
  - `req_ready[g]` equals that same condition. All other `req_ready` bits are 0, and every `req_ready` bit is 0 outside XFER.
  - On a transfer: `fifo_write_data` ← `req_data[g]`, `fifo_write_inc` ← 1, `burst_cnt`++, go to GAP.
  - If `req_valid[g]` is low: release the grant and go to IDLE.
  - If `req_valid[g]` is high but the FIFO is full: stay in XFER and hold the grant (stall).
- **GAP**
  - One mandatory dead cycle: `fifo_write_inc` ← 0 and `fifo_write_data` ← 0. This lets the FIFO full flag settle after each write.
  - Release the grant and go to IDLE if the last transfer had `req_last` high, or `burst_cnt == MAX_BURST`, or `arb_enable` is low.
  - Otherwise return to XFER with the same grant.
- **Release**
  - `rr_ptr` ← g.
  - `grant_onehot` ← 0.
  - The next search starts at g+1.
- `burst_cnt` is 8 bits wide and saturates at MAX_BURST. It never wraps.
- When `arb_enable` falls during XFER, the grant is released at the next GAP. Any word already accepted is always written.
- `req_data` of non-granted requesters is ignored.

## Timing
- **Reset values**
  - Outputs: `fifo_write_data`=0, `fifo_write_inc`=0, `grant_onehot`=0, `busy`=0, `req_ready`=0.
  - Internal: state IDLE, `rr_ptr`=NUM_REQ-1 (so requester 0 has first priority), `burst_cnt`=0.
- An asynchronous reset in any state aborts the burst immediately. A word accepted in the same cycle as reset assertion is lost.
- **Grant latency**
  - A request seen in IDLE at edge k produces a grant visible in cycle k+1.
  - The earliest `req_ready` is in cycle k+1.
  - The earliest `fifo_write_inc` is in cycle k+2.
- **Throughput:** one word per 2 cycles while granted and the FIFO is not full.
- **Release to next grant:** GAP → IDLE → XFER, so there is exactly one IDLE cycle between grants.
- `fifo_write_inc` is never high in two consecutive cycles.
- `fifo_write_data` is nonzero only in cycles where `fifo_write_inc` is high.
- `fifo_write_full` is sampled only in XFER. A full flag that rises during GAP stalls the next XFER.
- **Simultaneous requests:** the round-robin order is strictly by `rr_ptr`. There is no fixed priority after reset.

## Test plan
- **Single burst.** Stimulus: `req_valid[1]`=1, three words 0x1_0000_00A1..A3, `req_last` on the third. Required response:
  - `fifo_write_inc` pulses in cycles 2, 4, 6.
  - `grant_onehot`=0010 throughout.
  - IDLE in cycle 7.
  - `rr_ptr`=1.
- **Round-robin.** Stimulus: requesters 0 and 2 both continuously valid, each sending 1-word bursts with `req_last`=1. Required response: grants alternate 0, 2, 0, 2, with one IDLE cycle between grants.
- **Backpressure.** Stimulus: `fifo_write_full`=1 for 5 cycles during XFER with requester 3 valid. Required response:
  - `req_ready[3]`=0 and no `fifo_write_inc` for those 5 cycles.
  - Grant held.
  - The word is written 1 cycle after full drops.
- **Forced rotation.** Stimulus: MAX_BURST=4, requester 0 streams 10 words without `req_last`, requester 1 valid. Required response: after 4 writes the grant moves to requester 1, then returns to requester 0.
- **Enable drop.** Stimulus: `arb_enable`=0 one cycle after the first word of a 3-word burst is accepted. Required response:
  - Exactly 1 write.
  - Return to IDLE.
  - No new grant until `arb_enable`=1.
- **Reset mid-burst.** Stimulus: assert `preset_n`=0 in GAP. Required response:
  - All outputs 0 immediately.
  - After release, requester 0 is granted first when all requesters are valid.
